// File: rtl/mul_sequencer.sv
// ============================================================================
// Module   : mul_sequencer
// Brief    : Multi-cycle radix-2 shift-add multiply controller with early exit
//            for MULI/MULR/MULSI/MULSR. Stalls the pipeline, reads operands
//            from the register file, writes back the truncated product and
//            optionally updates NZCV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sequencer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mul_trigger,
   input  logic [1:0]        i_mul_type,
   input  logic [3:0]        i_dest_reg,
   input  logic [3:0]        i_src1_reg,
   input  logic [3:0]        i_src2_reg,
   input  logic [15:0]       i_imm,
   input  logic              i_flush,
   output logic [3:0]        o_rf_raddr1,
   output logic [3:0]        o_rf_raddr2,
   input  logic [DATA_W-1:0] i_rf_rdata1,
   input  logic [DATA_W-1:0] i_rf_rdata2,
   output logic              o_rf_we,
   output logic [3:0]        o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_flag_we,
   output logic [3:0]        o_flags_out,
   output logic              o_stall,
   output logic              o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_RUN  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t              r_state;

   // Instruction fields captured at trigger time
   logic [3:0]          r_dest;
   logic [3:0]          r_src1;
   logic [3:0]          r_src2;
   logic [1:0]          r_type;
   logic [15:0]         r_imm;

   // Datapath
   logic [DATA_W-1:0]   r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [DATA_W-1:0]   r_acc;
   logic [CNT_W-1:0]    r_cnt;

   // Write-back outputs, loaded on entry to WB and cleared everywhere else
   logic                r_we;
   logic                r_flag_we;
   logic [3:0]          r_waddr;
   logic [DATA_W-1:0]   r_wdata;
   logic [3:0]          r_flags;

   logic [DATA_W-1:0]   w_mplier_sel;
   logic [DATA_W-1:0]   w_acc_next;
   logic [DATA_W-1:0]   w_mplier_next;
   logic                w_run_last;

   // Operand selection and next-iteration values for the shift-add loop
   always_comb begin
      w_mplier_sel  = r_type[0] ? i_rf_rdata2 : {{(DATA_W-16){1'b0}}, r_imm};
      w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_mplier_next = r_mplier >> 1;
      w_run_last    = (w_mplier_next == '0) || (r_cnt == CNT_W'(DATA_W-1));
   end

   // Control FSM plus datapath; a flush outside IDLE abandons the operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_dest    <= '0;
         r_src1    <= '0;
         r_src2    <= '0;
         r_type    <= '0;
         r_imm     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_flag_we <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_flags   <= '0;
      end else begin
         r_we      <= 1'b0;
         r_flag_we <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_flags   <= '0;
         if ((r_state != S_IDLE) && i_flush) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_mul_trigger && !i_flush) begin
                     r_dest  <= i_dest_reg;
                     r_src1  <= i_src1_reg;
                     r_src2  <= i_src2_reg;
                     r_type  <= i_mul_type;
                     r_imm   <= i_imm;
                     r_state <= S_READ;
                  end
               end
               S_READ: begin
                  r_mcand  <= i_rf_rdata1;
                  r_mplier <= w_mplier_sel;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  if (w_mplier_sel == '0) begin
                     // Zero multiplier: product is zero, skip RUN entirely
                     r_state   <= S_WB;
                     r_we      <= 1'b1;
                     r_waddr   <= r_dest;
                     r_flag_we <= r_type[1];
                     r_flags   <= r_type[1] ? 4'b0100 : 4'b0000;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
               S_RUN: begin
                  r_acc    <= w_acc_next;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= w_mplier_next;
                  r_cnt    <= r_cnt + 1'b1;
                  if (w_run_last) begin
                     r_state   <= S_WB;
                     r_we      <= 1'b1;
                     r_waddr   <= r_dest;
                     r_wdata   <= w_acc_next;
                     r_flag_we <= r_type[1];
                     r_flags   <= r_type[1] ?
                                  {w_acc_next[DATA_W-1], (w_acc_next == '0), 2'b00} :
                                  4'b0000;
                  end
               end
               S_WB: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Output decode; write strobes are masked so a flush in WB writes nothing
   always_comb begin
      o_stall     = (r_state == S_IDLE) ? (i_mul_trigger && !rst) : 1'b1;
      o_rf_raddr1 = (r_state == S_READ) ? r_src1 : 4'd0;
      o_rf_raddr2 = (r_state == S_READ) ? r_src2 : 4'd0;
      o_rf_we     = r_we && !i_flush;
      o_done      = r_we && !i_flush;
      o_flag_we   = r_flag_we && !i_flush;
      o_rf_waddr  = r_waddr;
      o_rf_wdata  = r_wdata;
      o_flags_out = r_flags;
   end

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none

module tb_mul_sequencer;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   logic              clk;
   logic              rst;
   logic              mul_trigger;
   logic [1:0]        mul_type;
   logic [3:0]        dest_reg;
   logic [3:0]        src1_reg;
   logic [3:0]        src2_reg;
   logic [15:0]       imm;
   logic              flush;
   logic [3:0]        rf_raddr1;
   logic [3:0]        rf_raddr2;
   logic [DATA_W-1:0] rf_rdata1;
   logic [DATA_W-1:0] rf_rdata2;
   logic              rf_we;
   logic [3:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              flag_we;
   logic [3:0]        flags_out;
   logic              stall;
   logic              done;

   logic [DATA_W-1:0] regs [16];

   int n_checks;
   int n_errors;

   mul_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_mul_trigger (mul_trigger),
      .i_mul_type    (mul_type),
      .i_dest_reg    (dest_reg),
      .i_src1_reg    (src1_reg),
      .i_src2_reg    (src2_reg),
      .i_imm         (imm),
      .i_flush       (flush),
      .o_rf_raddr1   (rf_raddr1),
      .o_rf_raddr2   (rf_raddr2),
      .i_rf_rdata1   (rf_rdata1),
      .i_rf_rdata2   (rf_rdata2),
      .o_rf_we       (rf_we),
      .o_rf_waddr    (rf_waddr),
      .o_rf_wdata    (rf_wdata),
      .o_flag_we     (flag_we),
      .o_flags_out   (flags_out),
      .o_stall       (stall),
      .o_done        (done)
   );

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one multiply and follow it to write-back.
   // exp_lat is the WB cycle counted from the trigger cycle (T = 0).
   task automatic run_mul(input string tag, input logic [1:0] typ, input logic [3:0] d,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] im,
                          input logic [31:0] exp_data, input logic [3:0] exp_flags,
                          input int exp_lat);
      int  k;
      bit  found;
      bit  stall_ok;
      @(posedge clk); #1;
      mul_trigger = 1'b1; mul_type = typ; dest_reg = d;
      src1_reg = s1; src2_reg = s2; imm = im;
      @(negedge clk);
      check({tag, "_stall_T"}, 32'(stall), 32'd1);
      @(posedge clk); #1;
      mul_trigger = 1'b0;
      k = 1; found = 0; stall_ok = 1;
      while (k <= 60 && !found) begin
         @(negedge clk);
         if (!stall) stall_ok = 0;
         if (k == 1) check({tag, "_raddr1"}, 32'(rf_raddr1), 32'(s1));
         if (rf_we) begin
            found = 1;
            check({tag, "_wb_cycle"}, 32'(k), 32'(exp_lat));
            check({tag, "_waddr"},    32'(rf_waddr), 32'(d));
            check({tag, "_wdata"},    rf_wdata, exp_data);
            check({tag, "_done"},     32'(done), 32'd1);
            check({tag, "_flag_we"},  32'(flag_we), 32'(typ[1]));
            check({tag, "_flags"},    32'(flags_out), 32'(exp_flags));
         end else begin
            k++;
         end
      end
      if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
      check({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
      @(negedge clk);
      check({tag, "_stall_after"}, 32'(stall), 32'd0);
      check({tag, "_we_after"},    32'(rf_we), 32'd0);
   endtask

   initial begin
      int  seen_we;
      n_checks = 0; n_errors = 0;
      mul_trigger = 0; mul_type = 0; dest_reg = 0; src1_reg = 0;
      src2_reg = 0; imm = 0; flush = 0;
      for (int i = 0; i < 16; i++) regs[i] = 32'(i * 32'h11);
      regs[1] = 32'd6;
      regs[4] = 32'hFFFF_FFFF;
      regs[5] = 32'd3;
      regs[6] = 32'h0000_1234;
      regs[7] = 32'h0000_0010;
      regs[8] = 32'h8000_0000;
      regs[9] = 32'd2;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_stall",   32'(stall), 32'd0);
      check("rst_we",      32'(rf_we), 32'd0);
      check("rst_done",    32'(done), 32'd0);
      check("rst_flag_we", 32'(flag_we), 32'd0);
      check("rst_wdata",   rf_wdata, 32'd0);
      check("rst_raddr1",  32'(rf_raddr1), 32'd0);

      // MULI r3 = r1 * 7 -> 42, WB at T+5
      run_mul("muli7",   2'b00, 4'd3, 4'd1, 4'd0, 16'd7, 32'd42, 4'b0000, 5);
      // MULSR r2 = r4 * r5 -> 0xFFFFFFFD, N set
      run_mul("mulsr",   2'b11, 4'd2, 4'd4, 4'd5, 16'd0, 32'hFFFF_FFFD, 4'b1000, 4);
      // MULSI imm 0 -> zero product, Z set, no RUN cycles
      run_mul("mulsi0",  2'b10, 4'd6, 4'd1, 4'd0, 16'd0, 32'd0, 4'b0100, 2);
      // MULI imm 0x8000, r9 = 2 -> 0x10000, 16 RUN cycles
      run_mul("muli8k",  2'b00, 4'd5, 4'd9, 4'd0, 16'h8000, 32'h0001_0000, 4'b0000, 18);
      // MULR r10 = r6 * r7 -> 0x12340
      run_mul("mulr",    2'b01, 4'd10, 4'd6, 4'd7, 16'd0, 32'h0001_2340, 4'b0000, 7);
      // MULSR r11 = r5 * r8 : multiplier bit 31, full-length loop, truncated
      run_mul("mulsr31", 2'b11, 4'd11, 4'd5, 4'd8, 16'd0, 32'h8000_0000, 4'b1000, 34);

      // Flush during the third RUN cycle (cycle T+4)
      @(posedge clk); #1;
      mul_trigger = 1; mul_type = 2'b00; dest_reg = 4'd3; src1_reg = 4'd1; imm = 16'h00FF;
      @(posedge clk); #1;
      mul_trigger = 0;
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush_we_cycle", 32'(rf_we), 32'd0);
      @(posedge clk); #1 flush = 1'b0;
      seen_we = 0;
      @(negedge clk);
      check("flush_stall", 32'(stall), 32'd0);
      repeat (15) begin
         @(negedge clk);
         if (rf_we) seen_we++;
      end
      check("flush_no_we", 32'(seen_we), 32'd0);

      // Asynchronous reset mid-RUN
      @(posedge clk); #1;
      mul_trigger = 1; mul_type = 2'b11; dest_reg = 4'd2; src1_reg = 4'd4; src2_reg = 4'd8;
      @(posedge clk); #1;
      mul_trigger = 0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_stall", 32'(stall), 32'd0);
      check("arst_we",    32'(rf_we), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      run_mul("post_rst", 2'b00, 4'd3, 4'd1, 4'd0, 16'd7, 32'd42, 4'b0000, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
